// File: rtl/gsim_pkg.sv
// Shared definitions for the solver result collector: frame geometry,
// collector state encoding and the word index type.
package gsim_pkg;

    localparam int N_WORDS = 16;
    localparam int X_W     = 32;
    localparam int CNT_W   = 8;
    localparam int IDX_W   = 4;

    typedef logic [IDX_W-1:0] idx_t;

    // Collector state enumeration, kept as plain constants for legacy tools.
    typedef logic [1:0] state_t;
    localparam state_t S_IDLE    = 2'd0;
    localparam state_t S_CAPTURE = 2'd1;
    localparam state_t S_DRAIN   = 2'd2;

    function automatic logic is_last_idx(input idx_t idx, input int n_words);
        return idx == idx_t'(n_words - 1);
    endfunction

endpackage

// File: rtl/gsim_word_buf.sv
// Frame buffer: N_WORDS x X_W, one synchronous write port and one
// combinational read port. Contents are not reset.
module gsim_word_buf
    import gsim_pkg::*;
#(
    parameter int N_WORDS = gsim_pkg::N_WORDS,
    parameter int X_W     = gsim_pkg::X_W
) (
    input  logic           clk,
    input  logic           we,
    input  idx_t           waddr,
    input  logic [X_W-1:0] wdata,
    input  idx_t           raddr,
    output logic [X_W-1:0] rdata
);

    logic [X_W-1:0] mem [N_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/gsim_result_collector.sv
// Captures one frame of solver output words into a buffer and replays it
// through a valid/ready drain port, with sticky error flags and a frame counter.
module gsim_result_collector
    import gsim_pkg::*;
#(
    parameter int N_WORDS = gsim_pkg::N_WORDS,
    parameter int X_W     = gsim_pkg::X_W,
    parameter int CNT_W   = gsim_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst_in,
    input  logic             x_valid,
    input  logic [X_W-1:0]   x_in,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [X_W-1:0]   m_data,
    output idx_t             m_index,
    output logic             m_last,
    output logic             busy,
    output logic             overflow,
    output logic             short_frame,
    output logic [CNT_W-1:0] frame_cnt,
    input  logic             clr_err,
    output state_t           dbg_state
);

    localparam idx_t LAST_IDX = idx_t'(N_WORDS - 1);

    state_t         state, state_nxt;
    idx_t           wr_idx, wr_idx_nxt;
    idx_t           rd_idx, rd_idx_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic           buf_we;
    idx_t           buf_waddr;
    logic [X_W-1:0] buf_rdata;
    logic           short_set;
    logic           ovf_set;
    logic           in_drain;
    logic           xfer;

    gsim_word_buf #(
        .N_WORDS (N_WORDS),
        .X_W     (X_W)
    ) u_word_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (buf_waddr),
        .wdata (x_in),
        .raddr (rd_idx),
        .rdata (buf_rdata)
    );

    // Drain handshake: a word moves on every rising edge where m_valid && m_ready;
    // while m_valid is high and m_ready low, m_data/m_index/m_last hold steady.
    assign in_drain = (state == S_DRAIN);
    assign xfer     = in_drain && m_ready;

    always_comb begin
        state_nxt  = state;
        wr_idx_nxt = wr_idx;
        rd_idx_nxt = rd_idx;
        cnt_nxt    = frame_cnt;
        buf_we     = 1'b0;
        buf_waddr  = wr_idx;
        short_set  = 1'b0;
        ovf_set    = 1'b0;
        case (state)
            S_IDLE: begin
                if (x_valid) begin
                    buf_we    = 1'b1;
                    buf_waddr = '0;
                    if (LAST_IDX == '0) begin
                        state_nxt  = S_DRAIN;
                        wr_idx_nxt = '0;
                    end else begin
                        state_nxt  = S_CAPTURE;
                        wr_idx_nxt = idx_t'(1);
                    end
                end
            end
            S_CAPTURE: begin
                if (x_valid) begin
                    buf_we = 1'b1;
                    if (wr_idx == LAST_IDX) begin
                        state_nxt  = S_DRAIN;
                        wr_idx_nxt = '0;
                    end else begin
                        wr_idx_nxt = wr_idx + idx_t'(1);
                    end
                end else begin
                    // Stream broke before the frame was complete: drop it.
                    short_set  = 1'b1;
                    state_nxt  = S_IDLE;
                    wr_idx_nxt = '0;
                end
            end
            S_DRAIN: begin
                ovf_set = x_valid;
                if (xfer) begin
                    if (is_last_idx(rd_idx, N_WORDS)) begin
                        state_nxt  = S_IDLE;
                        rd_idx_nxt = '0;
                        cnt_nxt    = frame_cnt + CNT_W'(1);
                    end else begin
                        rd_idx_nxt = rd_idx + idx_t'(1);
                    end
                end
            end
            default: begin
                state_nxt  = S_IDLE;
                wr_idx_nxt = '0;
                rd_idx_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            state     <= S_IDLE;
            wr_idx    <= '0;
            rd_idx    <= '0;
            frame_cnt <= '0;
        end else begin
            state     <= state_nxt;
            wr_idx    <= wr_idx_nxt;
            rd_idx    <= rd_idx_nxt;
            frame_cnt <= cnt_nxt;
        end
    end

    // A new error in the same cycle as clr_err must survive the clear.
    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            overflow    <= 1'b0;
            short_frame <= 1'b0;
        end else begin
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (short_set) begin
                short_frame <= 1'b1;
            end else if (clr_err) begin
                short_frame <= 1'b0;
            end
        end
    end

    assign m_valid   = in_drain;
    assign m_data    = in_drain ? buf_rdata : '0;
    assign m_index   = in_drain ? rd_idx : '0;
    assign m_last    = in_drain && is_last_idx(rd_idx, N_WORDS);
    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_gsim_result_collector.sv
// Bench for gsim_result_collector: frame table plus hand sequences for
// overflow, reset mid-drain, flag clearing and frame counter wrap.
module tb_gsim_result_collector;
    import gsim_pkg::*;

    logic        clk = 1'b0;
    logic        rst_in;
    logic        x_valid;
    logic [31:0] x_in;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic [3:0]  m_index;
    logic        m_last;
    logic        busy;
    logic        overflow;
    logic        short_frame;
    logic [7:0]  frame_cnt;
    logic        clr_err;
    logic [1:0]  dbg_state;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [35:0] exp_q[$];
    logic [7:0]  exp_frame_cnt;

    typedef struct {
        int          n_words;
        logic [31:0] base;
        logic [31:0] step;
        int          ready_mode;
        bit          exp_short;
        int          exp_cycles;
    } vec_t;
    vec_t vecs[6];

    always #5 clk = ~clk;

    gsim_result_collector dut (
        .clk         (clk),
        .rst_in      (rst_in),
        .x_valid     (x_valid),
        .x_in        (x_in),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_index     (m_index),
        .m_last      (m_last),
        .busy        (busy),
        .overflow    (overflow),
        .short_frame (short_frame),
        .frame_cnt   (frame_cnt),
        .clr_err     (clr_err),
        .dbg_state   (dbg_state)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_words(input int n, input logic [31:0] base, input logic [31:0] step,
                              input bit push, input bit chk_lat);
        logic [31:0] w;
        for (int i = 0; i < n; i++) begin
            w       = base + step * 32'(i);
            x_valid = 1'b1;
            x_in    = w;
            if (push) exp_q.push_back({4'(i), w});
            tick();
            if (chk_lat && i < n - 1) check("capture_no_valid", m_valid, 0);
        end
        x_valid = 1'b0;
    endtask

    task automatic drain(input int mode, output int cycles);
        cycles = 0;
        while (busy && cycles < 200) begin
            m_ready = (mode == 0) ? 1'b1 : ((cycles % 2) == 0);
            tick();
            cycles++;
        end
        m_ready = 1'b0;
        check("drain_done", busy, 0);
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
    endtask

    // Output monitor: pops the scoreboard on every transfer, checks stall stability.
    initial begin : monitor
        logic        prev_stall;
        logic [31:0] prev_data;
        logic [3:0]  prev_idx;
        logic [35:0] e;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_idx   = '0;
        forever begin
            @(negedge clk);
            if (rst_in) begin
                prev_stall = 1'b0;
            end else if (m_valid) begin
                if (prev_stall) begin
                    check("stall_data", m_data, prev_data);
                    check("stall_index", m_index, prev_idx);
                end
                if (m_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_xfer: got data %0h index %0d, expected none", m_data, m_index);
                    end else begin
                        e = exp_q.pop_front();
                        check("m_data", m_data, e[31:0]);
                        check("m_index", m_index, e[35:32]);
                        check("m_last", m_last, e[35:32] == 4'd15);
                    end
                end
                prev_stall = !m_ready;
                prev_data  = m_data;
                prev_idx   = m_index;
            end else begin
                check("idle_data", m_data, 0);
                check("idle_last", m_last, 0);
                check("idle_index", m_index, 0);
                prev_stall = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int cyc;
        x_valid = 1'b0;
        x_in    = '0;
        m_ready = 1'b0;
        clr_err = 1'b0;
        rst_in  = 1'b1;
        exp_frame_cnt = '0;

        vecs[0] = '{16, 32'h0001_0000, 32'h0001_0000, 0, 1'b0, 16};
        vecs[1] = '{16, 32'h0001_0000, 32'h0001_0000, 1, 1'b0, 31};
        vecs[2] = '{10, 32'h0001_0000, 32'h0001_0000, 0, 1'b1, 0};
        vecs[3] = '{16, 32'h8000_0000, 32'h0000_0001, 0, 1'b0, 16};
        vecs[4] = '{16, 32'hFFFF_0000, 32'hFFFF_0000, 1, 1'b0, 31};
        vecs[5] = '{1,  32'h1234_5678, 32'h0000_0000, 0, 1'b1, 0};

        repeat (3) tick();
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_index", m_index, 0);
        check("rst_m_last", m_last, 0);
        check("rst_busy", busy, 0);
        check("rst_overflow", overflow, 0);
        check("rst_short", short_frame, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_state", dbg_state, S_IDLE);
        rst_in = 1'b0;
        tick();

        for (int v = 0; v < 6; v++) begin
            m_ready = 1'b0;
            send_words(vecs[v].n_words, vecs[v].base, vecs[v].step, !vecs[v].exp_short, 1'b1);
            if (vecs[v].exp_short) begin
                tick();
                check("short_set", short_frame, 1);
                check("short_idle", busy, 0);
                check("short_state", dbg_state, S_IDLE);
                check("short_no_valid", m_valid, 0);
                pulse_clr();
                check("short_clr", short_frame, 0);
            end else begin
                check("first_valid", m_valid, 1);
                check("first_index", m_index, 0);
                drain(vecs[v].ready_mode, cyc);
                check("drain_cycles", cyc, vecs[v].exp_cycles);
                exp_frame_cnt++;
                check("frame_cnt", frame_cnt, exp_frame_cnt);
                check("no_overflow", overflow, 0);
            end
        end

        // Short-frame detection coincides with clr_err: the set must win.
        send_words(5, 32'hC000_0000, 32'h1, 1'b0, 1'b0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("set_beats_clr", short_frame, 1);
        pulse_clr();
        check("short_clr2", short_frame, 0);

        // Second frame arrives while the first is stalled in the drain.
        m_ready = 1'b0;
        send_words(16, 32'hA000_0000, 32'h11, 1'b1, 1'b1);
        send_words(16, 32'h0000_5555, 32'h1, 1'b0, 1'b0);
        check("ovf_set", overflow, 1);
        check("ovf_busy", busy, 1);
        check("ovf_index", m_index, 0);
        check("ovf_data", m_data, 32'hA000_0000);
        drain(0, cyc);
        check("ovf_drain_cycles", cyc, 16);
        exp_frame_cnt++;
        check("ovf_frame_cnt", frame_cnt, exp_frame_cnt);
        check("ovf_sticky", overflow, 1);
        pulse_clr();
        check("ovf_clr", overflow, 0);

        // x_valid on the final transfer cycle: flagged, not captured.
        send_words(16, 32'h1234_0000, 32'h100, 1'b1, 1'b1);
        m_ready = 1'b1;
        repeat (15) tick();
        x_valid = 1'b1;
        x_in    = 32'hDEAD_BEEF;
        tick();
        x_valid = 1'b0;
        m_ready = 1'b0;
        exp_frame_cnt++;
        check("final_ovf", overflow, 1);
        check("final_idle", busy, 0);
        check("final_frame_cnt", frame_cnt, exp_frame_cnt);
        check("final_q_empty", exp_q.size(), 0);

        // Reset after five drained words, with both flags set.
        send_words(3, 32'h0, 32'h1, 1'b0, 1'b0);
        tick();
        check("pre_rst_short", short_frame, 1);
        send_words(16, 32'h7000_0000, 32'h3, 1'b1, 1'b1);
        m_ready = 1'b1;
        repeat (5) tick();
        m_ready = 1'b0;
        #1;
        rst_in = 1'b1;
        #1;
        check("mid_rst_m_valid", m_valid, 0);
        check("mid_rst_m_data", m_data, 0);
        check("mid_rst_m_index", m_index, 0);
        check("mid_rst_m_last", m_last, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_cnt", frame_cnt, 0);
        check("mid_rst_ovf", overflow, 0);
        check("mid_rst_short", short_frame, 0);
        check("mid_rst_remaining", exp_q.size(), 11);
        exp_q.delete();
        exp_frame_cnt = '0;
        tick();
        rst_in = 1'b0;
        tick();
        send_words(16, 32'h0BAD_0000, 32'h7, 1'b1, 1'b1);
        check("post_rst_index", m_index, 0);
        drain(0, cyc);
        exp_frame_cnt++;
        check("post_rst_cnt", frame_cnt, exp_frame_cnt);

        // 255 more frames bring the count since reset to 256.
        for (int f = 0; f < 255; f++) begin
            send_words(16, $urandom, $urandom, 1'b1, 1'b0);
            drain(0, cyc);
            exp_frame_cnt++;
            check("wrap_frame_cnt", frame_cnt, exp_frame_cnt);
        end
        check("wrap_zero", frame_cnt, 0);
        check("end_q_empty", exp_q.size(), 0);
        check("end_flags", {overflow, short_frame}, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
